// File: rtl/dw_converter_arbiter_if.sv
// dw_converter_arbiter_if: requester streams in, one converter stream out, plus owner tag and busy.
interface dw_converter_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DW      = 512,
   parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();
   logic [NUM_REQ*DW-1:0] req_data_i;
   logic [NUM_REQ-1:0]    req_valid_i;
   logic [NUM_REQ-1:0]    req_last_i;
   logic [NUM_REQ-1:0]    req_ready_o;
   logic [DW-1:0]         conv_data_o;
   logic                  conv_valid_o;
   logic                  conv_ready_i;
   logic                  conv_last_o;
   logic [IDW-1:0]        conv_id_o;
   logic                  busy_o;
   modport master (
      output req_data_i, req_valid_i, req_last_i, conv_ready_i,
      input  req_ready_o, conv_data_o, conv_valid_o, conv_last_o, conv_id_o, busy_o
   );
   modport slave (
      input  req_data_i, req_valid_i, req_last_i, conv_ready_i,
      output req_ready_o, conv_data_o, conv_valid_o, conv_last_o, conv_id_o, busy_o
   );
endinterface

// File: rtl/dw_converter_arbiter.sv
// dw_converter_arbiter: round-robin, burst-granular sharing of one converter input among NUM_REQ streams.
module dw_converter_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DW        = 512,
   parameter int BURST_LEN = 8,
   parameter int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input logic clk_i,
   input logic rst_ni,
   dw_converter_arbiter_if.slave bus
);
   localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   typedef enum logic {IDLE, GRANT} state_t;
   state_t         state;
   logic [IDW-1:0] owner, rr_ptr, pick, idx, nxt;
   logic [CW-1:0]  beat_cnt;
   logic           grant, fire, last, found;
   always_comb begin
      pick  = rr_ptr;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
         if (!found && bus.req_valid_i[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      nxt   = (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      grant = state == GRANT;
      last  = grant & (bus.req_last_i[owner] | (beat_cnt == CW'(BURST_LEN - 1)));
      fire  = grant & bus.req_valid_i[owner] & bus.conv_ready_i;
      bus.conv_data_o  = grant ? bus.req_data_i[int'(owner)*DW +: DW] : '0;
      bus.conv_valid_o = grant & bus.req_valid_i[owner];
      bus.req_ready_o  = (grant & bus.conv_ready_i) ? (NUM_REQ'(1) << owner) : '0;
      bus.conv_last_o  = last;
      bus.conv_id_o    = grant ? owner : '0;
      bus.busy_o       = grant;
   end
   // The counter only moves on transferred beats, so stalls never shorten a burst.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else if (state == IDLE) begin
         if (|bus.req_valid_i) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= GRANT;
         end
      end else if (fire) begin
         if (last) begin
            state    <= IDLE;
            rr_ptr   <= nxt;
            beat_cnt <= '0;
         end else begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dw_converter_arbiter.sv
// tb_dw_converter_arbiter: scoreboard bench; expected beats are queued per scenario and popped on each transfer.
module tb_dw_converter_arbiter;
   localparam int NR = 4, DW = 32, BL = 8, IDW = 2;
   logic clk = 1'b0, rst_n = 1'b0;
   dw_converter_arbiter_if #(.NUM_REQ(NR), .DW(DW), .IDW(IDW)) bus ();
   dw_converter_arbiter #(.NUM_REQ(NR), .DW(DW), .BURST_LEN(BL), .IDW(IDW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {logic [IDW-1:0] id; logic [DW-1:0] d; logic l;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0, nx = 0, cyc = 0;
   int xc[64];
   int lastlen[NR];
   int sq[NR];
   logic [NR-1:0] en = '0;
   logic rdy = 1'b1, tog = 1'b0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [DW-1:0] mk(input int k, input int s);
      return DW'(k * 65536 + s);
   endfunction
   task automatic push(input int k, input int s, input logic l);
      q.push_back('{id: IDW'(k), d: mk(k, s), l: l});
   endtask
   task automatic drive();
      if (tog) rdy = ~rdy;
      for (int k = 0; k < NR; k++) begin
         bus.req_valid_i[k]         = en[k];
         bus.req_data_i[k*DW +: DW] = mk(k, sq[k]);
         bus.req_last_i[k]          = (lastlen[k] != 0) && (sq[k] % lastlen[k] == lastlen[k] - 1);
      end
      bus.conv_ready_i = rdy;
   endtask
   task automatic tick();
      exp_t e;
      logic [NR-1:0] er;
      @(negedge clk);
      drive();
      #1;
      er = bus.busy_o ? (NR'(rdy) << bus.conv_id_o) : '0;
      check("ready_route", 32'(bus.req_ready_o), 32'(er));
      if (bus.conv_valid_o && bus.conv_ready_i) begin
         if (q.size() == 0) check("unexpected_beat", 32'(bus.conv_data_o), 32'hdead_beef);
         else begin
            e = q.pop_front();
            check("id", 32'(bus.conv_id_o), 32'(e.id));
            check("data", bus.conv_data_o, e.d);
            check("last", 32'(bus.conv_last_o), 32'(e.l));
         end
         for (int k = 0; k < NR; k++) if (bus.req_valid_i[k] && bus.req_ready_o[k]) sq[k]++;
         if (nx < 64) xc[nx] = cyc;
         nx++;
      end
      cyc++;
   endtask
   task automatic run_until(input int n, input logic stop);
      int g = 0;
      while (nx < n && g < 300) begin
         tick();
         g++;
      end
      check("xfer_count", nx, n);
      if (stop) en = '0;
   endtask
   task automatic start();
      nx  = 0;
      cyc = 0;
      for (int k = 0; k < NR; k++) sq[k] = 0;
   endtask
   initial begin
      for (int k = 0; k < NR; k++) lastlen[k] = 2;
      bus.req_data_i = '0; bus.req_valid_i = '0; bus.req_last_i = '0; bus.conv_ready_i = 1'b0;
      // reset holds every output low despite all valids, then req 0 wins first
      en = '1;
      start();
      repeat (3) tick();
      check("rst_busy", 32'(bus.busy_o), 0);
      check("rst_valid", 32'(bus.conv_valid_o), 0);
      check("rst_last", 32'(bus.conv_last_o), 0);
      check("rst_id", 32'(bus.conv_id_o), 0);
      check("rst_data", bus.conv_data_o, 0);
      for (int r = 0; r < NR; r++) begin
         push(r, 0, 1'b0);
         push(r, 1, 1'b1);
      end
      push(0, 2, 1'b0);
      push(0, 3, 1'b1);
      @(negedge clk) rst_n = 1'b1;
      run_until(10, 1'b1);
      for (int i = 1; i < 10; i++) check("rr_gap", xc[i] - xc[0], (i / 2) * 3 + i % 2);
      check("q_empty_rr", q.size(), 0);
      // burst cap without req_last, then one bubble and a re-grant
      start();
      lastlen[2] = 0;
      en = 4'b0100;
      for (int j = 0; j < 16; j++) push(2, j, j % 8 == 7);
      run_until(16, 1'b1);
      for (int j = 1; j < 16; j++) check("cap_gap", xc[j] - xc[0], j + (j >= 8 ? 1 : 0));
      check("q_empty_cap", q.size(), 0);
      // ready toggling: one transfer every other cycle, beat count unaffected by stalls
      start();
      lastlen[1] = 4;
      en = 4'b0010;
      tog = 1'b1;
      for (int j = 0; j < 4; j++) push(1, j, j == 3);
      run_until(4, 1'b1);
      for (int j = 1; j < 4; j++) check("bp_gap", xc[j] - xc[0], 2 * j);
      start();
      lastlen[1] = 0;
      en = 4'b0010;
      for (int j = 0; j < 8; j++) push(1, j, j == 7);
      run_until(8, 1'b1);
      tog = 1'b0;
      rdy = 1'b1;
      check("q_empty_bp", q.size(), 0);
      // owner 3 idles mid-burst; req 0 waits for its final beat
      start();
      lastlen[3] = 4;
      lastlen[0] = 2;
      en = 4'b1001;
      for (int j = 0; j < 4; j++) push(3, j, j == 3);
      push(0, 0, 1'b0);
      push(0, 1, 1'b1);
      run_until(2, 1'b0);
      en[3] = 1'b0;
      repeat (5) begin
         tick();
         check("hold_busy", 32'(bus.busy_o), 1);
         check("hold_id", 32'(bus.conv_id_o), 3);
         check("hold_valid", 32'(bus.conv_valid_o), 0);
      end
      en[3] = 1'b1;
      run_until(6, 1'b1);
      check("q_empty_hold", q.size(), 0);
      // asynchronous reset on beat 3 drops the burst and rewinds rr_ptr
      start();
      lastlen[1] = 0;
      en = 4'b0010;
      push(1, 0, 1'b0);
      push(1, 1, 1'b0);
      run_until(2, 1'b0);
      @(negedge clk);
      drive();
      #1;
      check("beat3_valid", 32'(bus.conv_valid_o), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(bus.busy_o), 0);
      check("arst_valid", 32'(bus.conv_valid_o), 0);
      start();
      en = '1;
      for (int k = 0; k < NR; k++) lastlen[k] = 1;
      push(0, 0, 1'b1);
      drive();
      @(negedge clk) rst_n = 1'b1;
      run_until(1, 1'b1);
      repeat (2) tick();
      check("q_empty_arst", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
